// File: rtl/ycr_serial_debug_rx.sv
// Serial debug stream receiver: deserializes LSB-first frames framed by a
// one-cycle sync pulse on bit 0, tracks frame lock, flags sync violations,
// raises a masked-match trigger and keeps saturating frame/error counters.
module ycr_serial_debug_rx #(
    parameter int DEBUG_WD = 64,
    parameter int CNT_WD   = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                serial_debug_data,
    input  logic                serial_debug_sync,
    input  logic [DEBUG_WD-1:0] match_val,
    input  logic [DEBUG_WD-1:0] match_mask,
    input  logic                clr_cnt,
    output logic [DEBUG_WD-1:0] debug_word,
    output logic                debug_valid,
    output logic                debug_trig,
    output logic                debug_locked,
    output logic                sync_err,
    output logic [CNT_WD-1:0]   frame_cnt,
    output logic [CNT_WD-1:0]   err_cnt
);

    localparam int BCW = $clog2(DEBUG_WD);
    localparam logic [BCW-1:0] LAST_BIT = BCW'(DEBUG_WD - 1);
    localparam logic [BCW-1:0] ONE      = BCW'(1);

    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        RECV  = 2'd1,
        CHECK = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [BCW-1:0]      bit_cnt_q, bit_cnt_d;
    logic [DEBUG_WD-1:0] sr_q, sr_d;
    logic [DEBUG_WD-1:0] word_q, word_d;
    logic                valid_q, valid_d;
    logic                trig_q, trig_d;
    logic                locked_q, locked_d;
    logic                err_q, err_d;
    logic [CNT_WD-1:0]   fcnt_q, fcnt_d;
    logic [CNT_WD-1:0]   ecnt_q, ecnt_d;

    // Bits arrive LSB first, so shifting in from the top leaves bit 0 at the
    // bottom once DEBUG_WD bits have been taken.
    logic [DEBUG_WD-1:0] sr_shift;
    assign sr_shift = {serial_debug_data, sr_q[DEBUG_WD-1:1]};

    // State and datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= HUNT;
            bit_cnt_q <= '0;
            sr_q      <= '0;
            word_q    <= '0;
            valid_q   <= 1'b0;
            trig_q    <= 1'b0;
            locked_q  <= 1'b0;
            err_q     <= 1'b0;
            fcnt_q    <= '0;
            ecnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            sr_q      <= sr_d;
            word_q    <= word_d;
            valid_q   <= valid_d;
            trig_q    <= trig_d;
            locked_q  <= locked_d;
            err_q     <= err_d;
            fcnt_q    <= fcnt_d;
            ecnt_q    <= ecnt_d;
        end
    end

    // Framing FSM: next state, bit capture, word delivery and lock/error flags
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        sr_d      = sr_q;
        word_d    = word_q;
        valid_d   = 1'b0;
        trig_d    = 1'b0;
        err_d     = 1'b0;
        locked_d  = locked_q;
        unique case (state_q)
            HUNT: begin
                if (serial_debug_sync) begin
                    sr_d      = sr_shift;
                    bit_cnt_d = ONE;
                    state_d   = RECV;
                end
            end
            RECV: begin
                sr_d = sr_shift;
                if (serial_debug_sync && bit_cnt_q != '0) begin
                    // Early sync: drop the partial frame, this bit becomes bit 0
                    err_d     = 1'b1;
                    locked_d  = 1'b0;
                    bit_cnt_d = ONE;
                end else if (bit_cnt_q == LAST_BIT) begin
                    word_d    = sr_shift;
                    valid_d   = 1'b1;
                    trig_d    = ((sr_shift ^ match_val) & match_mask) == '0;
                    bit_cnt_d = '0;
                    state_d   = CHECK;
                end else begin
                    bit_cnt_d = bit_cnt_q + ONE;
                end
            end
            CHECK: begin
                if (serial_debug_sync) begin
                    // On-time sync after a full frame is what establishes lock
                    sr_d      = sr_shift;
                    bit_cnt_d = ONE;
                    locked_d  = 1'b1;
                    state_d   = RECV;
                end else begin
                    err_d     = 1'b1;
                    locked_d  = 1'b0;
                    bit_cnt_d = '0;
                    state_d   = HUNT;
                end
            end
            default: begin
                state_d   = HUNT;
                bit_cnt_d = '0;
            end
        endcase
    end

    // Saturating counters; they count the cycle a pulse is visible so a
    // clear issued during that pulse wins over the increment
    always_comb begin
        fcnt_d = fcnt_q;
        ecnt_d = ecnt_q;
        if (clr_cnt) begin
            fcnt_d = '0;
            ecnt_d = '0;
        end else begin
            if (valid_q && fcnt_q != '1) fcnt_d = fcnt_q + CNT_WD'(1);
            if (err_q && ecnt_q != '1)   ecnt_d = ecnt_q + CNT_WD'(1);
        end
    end

    assign debug_word   = word_q;
    assign debug_valid  = valid_q;
    assign debug_trig   = trig_q;
    assign debug_locked = locked_q;
    assign sync_err     = err_q;
    assign frame_cnt    = fcnt_q;
    assign err_cnt      = ecnt_q;

endmodule

// File: doc/ycr_serial_debug_rx.md
Name: ycr_serial_debug_rx

Overview:
- Receiver/deserializer for the two-wire serial debug stream (data + sync) emitted by the core's serial debug transmitter.
- Sits at the capture end: chip-level debug logic or an FPGA/bench monitor.
- Recovers DEBUG_WD-bit debug words, tracks frame lock and flags sync errors.
- Provides a masked-match trigger for logic-analyser style capture.

Parameters:
- DEBUG_WD, 64, frame/word width in bits; legal range 2..255.
- CNT_WD, 16, width of the frame and error counters.

Ports:
- clk  input  1  core clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- serial_debug_data  input  1  serial data, LSB first, one bit per clk.
- serial_debug_sync  input  1  one-cycle pulse coincident with bit 0 of each frame.
- match_val  input  DEBUG_WD  trigger compare value.
- match_mask  input  DEBUG_WD  trigger mask; 1 = bit compared.
- clr_cnt  input  1  synchronous clear of frame_cnt/err_cnt.
- debug_word  output  DEBUG_WD  last complete received word.
- debug_valid  output  1  one-cycle pulse when debug_word updates.
- debug_trig  output  1  one-cycle pulse, coincident with debug_valid, on masked match.
- debug_locked  output  1  frame lock indicator.
- sync_err  output  1  one-cycle pulse on a sync protocol violation.
- frame_cnt  output  CNT_WD  good frames received, saturating.
- err_cnt  output  CNT_WD  sync errors, saturating.

Behaviour:
- Reset (async, reset_n=0): all outputs 0, state HUNT, bit_cnt 0, shift register 0.
- Protocol: frames are back-to-back, period DEBUG_WD cycles. The sync edge carries bit 0; the following DEBUG_WD-1 edges carry bits 1..DEBUG_WD-1.
- State machine:
  - HUNT: ignore data until sync=1. On that edge, store bit 0, set bit_cnt=1, go RECV.
  - RECV: each edge, store data at position bit_cnt and increment bit_cnt. On the edge with bit_cnt==DEBUG_WD-1, store the last bit and register the full word into debug_word with debug_valid=1 at that same edge (word visible the cycle after the last bit); bit_cnt wraps to 0 and the state moves to CHECK.
  - CHECK (next edge is the expected bit 0): if sync=1, store bit 0, bit_cnt=1, debug_locked<=1, go RECV. If sync=0, pulse sync_err, debug_locked<=0, go HUNT; this data bit is discarded.
- Early sync: sync=1 in RECV with bit_cnt!=0 discards the partial frame, pulses sync_err, clears debug_locked, treats the current bit as bit 0 (bit_cnt=1) and stays in RECV. No debug_valid is produced for the discarded partial frame.
- Lock: debug_locked sets only at a correct on-time sync after a completed frame, so the first frame after HUNT is delivered unlocked. It clears on any sync_err.
- debug_word holds its value between valid pulses. It is never partially updated.
- debug_trig = valid and ((word ^ match_val) & match_mask)==0, evaluated on the completed word in the same cycle. match_mask=0 triggers on every frame.
- frame_cnt increments on each debug_valid; err_cnt increments on each sync_err. Both saturate at all-ones.
- clr_cnt zeroes both counters and has priority over a simultaneous increment.
- Reset mid-frame aborts immediately. Receive restarts in HUNT with no valid pulse.

Test Plan (bench DEBUG_WD=8):
- Clean stream of frames 0xA5, 0x3C, 0xFF -> debug_valid 3 pulses, each one cycle after the last bit. debug_word = A5, 3C, FF; debug_locked 0 on the first frame, 1 from the second sync on. frame_cnt=3, err_cnt=0.
- Sync withheld at the start of the 3rd frame -> sync_err pulse, debug_locked=0, state HUNT. No valid until the next sync; the following frame (0x5A) is received correctly. err_cnt=1.
- Extra sync at bit 4 of a frame -> sync_err pulse, partial frame dropped, new frame starts from that bit. Next valid word equals the 8 bits starting at the early sync.
- match_val=0x30, match_mask=0xF0; send 0x3C then 0x4C -> debug_trig pulses with the 0x3C valid only.
- Assert reset_n=0 at bit 5 of a frame -> all outputs 0 asynchronously. After release, no valid until a fresh sync plus 8 bits.
- Force frame_cnt near all-ones (CNT_WD=4, send 17 frames) -> frame_cnt holds at 0xF. clr_cnt concurrent with a valid pulse -> frame_cnt=0.
